// File: rtl/plab3_mem_wben_coalescer.sv
// Store-coalescing buffer: decodes 1/2/4-byte stores into line byte enables and
// merges same-line, same-domain stores into a single line write.
module plab3_mem_wben_coalescer #(
  parameter int unsigned p_addr_nbits  = 32,
  parameter int unsigned p_line_nbytes = 16,
  parameter int unsigned p_timeout     = 8
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_domain,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [p_addr_nbits-1:0]    in_addr,
  input  logic [1:0]                 in_len,
  input  logic [31:0]                in_data,
  input  logic                       flush,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic                       out_domain,
  output logic [p_addr_nbits-1:0]    out_addr,
  output logic [8*p_line_nbytes-1:0] out_data,
  output logic [p_line_nbytes-1:0]   out_wben,
  output logic                       err
);

  localparam int unsigned LW = 8 * p_line_nbytes;
  localparam int unsigned OW = $clog2(p_line_nbytes);
  localparam int unsigned TW = $clog2(p_timeout + 1);
  localparam logic [TW-1:0] TLAST = TW'(p_timeout - 1);

  typedef enum logic [1:0] {EMPTY, ACCUM, DRAIN} state_t;

  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;

  logic [OW-1:0]           off;
  logic [3:0]              smask;
  logic [31:0]             sbytes;
  logic                    legal;
  logic                    hit;
  logic [p_line_nbytes-1:0] s_wben;
  logic [LW-1:0]           s_data;
  logic [LW-1:0]           merge_data;
  logic [p_addr_nbits-1:0] line_addr;

  logic                     dom_n, err_n, merged;
  logic [p_addr_nbits-1:0]  tag_n;
  logic [LW-1:0]            data_n;
  logic [p_line_nbytes-1:0] wben_n;

  // Store decode; out_addr/out_domain double as the buffered tag and domain.
  always_comb begin
    off   = in_addr[OW-1:0];
    legal = 1'b0;
    smask = 4'h0;
    case (in_len)
      2'd0: begin legal = (in_addr[1:0] == 2'b00); smask = 4'hF; end
      2'd1: begin legal = 1'b1;                    smask = 4'h1; end
      2'd2: begin legal = ~in_addr[0];             smask = 4'h3; end
      default: begin legal = 1'b0;                 smask = 4'h0; end
    endcase
    sbytes    = in_data & {{8{smask[3]}}, {8{smask[2]}}, {8{smask[1]}}, {8{smask[0]}}};
    s_wben    = p_line_nbytes'(smask) << off;
    s_data    = LW'(sbytes) << {off, 3'b000};
    line_addr = {in_addr[p_addr_nbits-1:OW], {OW{1'b0}}};
    hit       = (state == ACCUM) && (line_addr == out_addr) && (in_domain == out_domain);
    merge_data = out_data;
    for (int unsigned i = 0; i < p_line_nbytes; i++) begin
      if (s_wben[i]) merge_data[8*i +: 8] = s_data[8*i +: 8];
    end
  end

  always_comb begin
    state_n = state;
    in_rdy  = 1'b1;
    tag_n   = out_addr;
    dom_n   = out_domain;
    data_n  = out_data;
    wben_n  = out_wben;
    cnt_n   = cnt;
    err_n   = 1'b0;
    merged  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_val) begin
          if (legal) begin
            tag_n   = line_addr;
            dom_n   = in_domain;
            data_n  = s_data;
            wben_n  = s_wben;
            cnt_n   = '0;
            state_n = ACCUM;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ACCUM: begin
        in_rdy = in_val ? (hit || !legal) : 1'b1;
        if (in_val && !legal) err_n = 1'b1;
        if (in_val && legal && hit) begin
          data_n = merge_data;
          wben_n = out_wben | s_wben;
          cnt_n  = '0;
          merged = 1'b1;
        end
        // A presented miss is not accepted; it waits for the drain to reload.
        if ((&wben_n) || (in_val && legal && !hit) || flush ||
            (!merged && cnt == TLAST)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else if (!merged) begin
          cnt_n = cnt + TW'(1);
        end
      end
      DRAIN: begin
        in_rdy = out_rdy;
        if (out_rdy) begin
          if (in_val && legal) begin
            tag_n   = line_addr;
            dom_n   = in_domain;
            data_n  = s_data;
            wben_n  = s_wben;
            cnt_n   = '0;
            state_n = ACCUM;
          end else begin
            data_n  = '0;
            wben_n  = '0;
            state_n = EMPTY;
            err_n   = in_val;
          end
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_val    <= 1'b0;
      err        <= 1'b0;
      out_wben   <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      out_domain <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      out_val    <= (state_n == DRAIN);
      err        <= err_n;
      out_wben   <= wben_n;
      out_data   <= data_n;
      out_addr   <= tag_n;
      out_domain <= dom_n;
      cnt        <= cnt_n;
    end
  end

endmodule

// File: tb/tb_plab3_mem_wben_coalescer.sv
// Scoreboard bench for the store coalescer: expected line writes are queued by
// the stimulus and checked by an independent monitor on every out fire.
module tb_plab3_mem_wben_coalescer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_domain, in_val, in_rdy, flush;
  logic [31:0]  in_addr, in_data;
  logic [1:0]   in_len;
  logic         out_val, out_rdy, out_domain, err;
  logic [31:0]  out_addr;
  logic [127:0] out_data;
  logic [15:0]  out_wben;

  typedef struct {
    logic [31:0]  addr;
    logic [15:0]  wben;
    logic [127:0] data;
    logic         dom;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int err_seen = 0;
  int err_exp = 0;

  plab3_mem_wben_coalescer #(
    .p_addr_nbits (32),
    .p_line_nbytes(16),
    .p_timeout    (8)
  ) dut (
    .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val),
    .in_rdy(in_rdy), .in_addr(in_addr), .in_len(in_len), .in_data(in_data),
    .flush(flush), .out_val(out_val), .out_rdy(out_rdy), .out_domain(out_domain),
    .out_addr(out_addr), .out_data(out_data), .out_wben(out_wben), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out fire is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && err === 1'b1) err_seen++;
    if (reset === 1'b1 && out_val === 1'b1 && out_rdy === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {96'd0, out_addr}, 128'd0);
      end else begin
        mon_e = q.pop_front();
        chk("out_addr",   {96'd0, out_addr},   {96'd0, mon_e.addr});
        chk("out_wben",   {112'd0, out_wben},  {112'd0, mon_e.wben});
        chk("out_data",   out_data,            mon_e.data);
        chk("out_domain", {127'd0, out_domain}, {127'd0, mon_e.dom});
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [15:0] w, input logic [127:0] d, input logic dm);
    exp_t e;
    e.addr = a; e.wben = w; e.data = d; e.dom = dm;
    q.push_back(e);
  endtask

  // Drives one store and returns just after the edge on which it was accepted.
  task automatic store(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d, input logic dm);
    bit done = 0;
    in_val = 1'b1; in_addr = a; in_len = l; in_data = d; in_domain = dm;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (in_rdy === 1'b1);
      tick();
    end
    if (!done) chk("store_timeout", 128'd0, 128'd1);
    in_val = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("drain_done", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_val = 1'b0; in_addr = '0; in_len = '0; in_data = '0;
    in_domain = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    #3;
    chk("rst_out_val", {127'd0, out_val}, 128'd0);
    chk("rst_err",     {127'd0, err},     128'd0);
    chk("rst_wben",    {112'd0, out_wben}, 128'd0);
    chk("rst_data",    out_data,          128'd0);
    chk("rst_addr",    {96'd0, out_addr}, 128'd0);
    chk("rst_dom",     {127'd0, out_domain}, 128'd0);
    chk("rst_in_rdy",  {127'd0, in_rdy},  128'd1);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Four word stores complete the line.
    push(32'h100, 16'hFFFF, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 1'b0);
    store(32'h100, 2'd0, 32'h11223344, 1'b0);
    store(32'h104, 2'd0, 32'h55667788, 1'b0);
    store(32'h108, 2'd0, 32'h99AABBCC, 1'b0);
    store(32'h10C, 2'd0, 32'hDDEEFF00, 1'b0);
    chk("full_latency", {127'd0, out_val}, 128'd1);
    wait_drain();
    tick();

    // Two byte stores to the same byte, then idle timeout.
    push(32'h200, 16'h0008, 128'h22000000, 1'b0);
    store(32'h203, 2'd1, 32'h00000011, 1'b0);
    store(32'h203, 2'd1, 32'h00000022, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      chk("idle_no_early_drain", {127'd0, out_val}, 128'd0);
      tick();
    end
    tick();
    chk("idle_drain_time", {127'd0, out_val}, 128'd1);
    wait_drain();
    tick();

    // Domain change forces drain; second line carries only domain-1 bytes.
    push(32'h300, 16'h000F, 128'hAAAAAAAA, 1'b0);
    push(32'h300, 16'h00F0, {64'd0, 32'hBBBBBBBB, 32'd0}, 1'b1);
    store(32'h300, 2'd0, 32'hAAAAAAAA, 1'b0);
    in_val = 1'b1; in_addr = 32'h304; in_len = 2'd0; in_data = 32'hBBBBBBBB; in_domain = 1'b1;
    #1;
    chk("domain_stall", {127'd0, in_rdy}, 128'd0);
    store(32'h304, 2'd0, 32'hBBBBBBBB, 1'b1);
    wait_drain();
    tick();

    // Illegal stores: misaligned half-word and len=3.
    store(32'h101, 2'd2, 32'h0000BEEF, 1'b0);
    chk("err_misaligned", {127'd0, err}, 128'd1);
    store(32'h100, 2'd3, 32'h12345678, 1'b0);
    chk("err_len3", {127'd0, err}, 128'd1);
    err_exp += 2;
    tick();
    chk("illegal_err_drop", {127'd0, err},      128'd0);
    chk("illegal_no_out",   {127'd0, out_val},  128'd0);
    chk("illegal_empty",    {112'd0, out_wben}, 128'd0);

    // Backpressure in DRAIN with a pending store to a new line, then reload.
    push(32'h400, 16'h000F, 128'h11111111, 1'b0);
    push(32'h500, 16'h000F, 128'h22222222, 1'b0);
    store(32'h400, 2'd0, 32'h11111111, 1'b0);
    out_rdy = 1'b0;
    in_val = 1'b1; in_addr = 32'h500; in_len = 2'd0; in_data = 32'h22222222; in_domain = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy",   {127'd0, in_rdy},   128'd0);
      chk("bp_out_val",  {127'd0, out_val},  128'd1);
      chk("bp_out_addr", {96'd0, out_addr},  128'h400);
      chk("bp_out_wben", {112'd0, out_wben}, 128'h000F);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", {127'd0, in_rdy}, 128'd1);
    tick();
    in_val = 1'b0;
    chk("reload_accum_val", {127'd0, out_val}, 128'd0);
    chk("reload_tag",       {96'd0, out_addr}, 128'h500);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drain", {127'd0, out_val}, 128'd1);
    wait_drain();
    tick();

    // Reset mid-ACCUM: buffered store is discarded.
    store(32'h600, 2'd0, 32'hCAFEF00D, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_accum_wben", {112'd0, out_wben}, 128'd0);
    chk("rst_accum_data", out_data,           128'd0);
    chk("rst_accum_addr", {96'd0, out_addr},  128'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("rst_accum_quiet", {127'd0, out_val}, 128'd0);
      tick();
    end

    // Reset mid-DRAIN: no partial write issued.
    store(32'h700, 2'd0, 32'h0BADBEEF, 1'b1);
    out_rdy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pre_rst_drain", {127'd0, out_val}, 128'd1);
    reset = 1'b0;
    #1;
    chk("rst_drain_val",  {127'd0, out_val},    128'd0);
    chk("rst_drain_data", out_data,             128'd0);
    chk("rst_drain_dom",  {127'd0, out_domain}, 128'd0);
    tick();
    reset = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("rst_drain_quiet", {127'd0, out_val}, 128'd0);
      tick();
    end

    chk("err_count",   128'(err_seen), 128'(err_exp));
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
